// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable integer clock divider with a glitch-free ratio-change handshake.
// The divided clock is a registered output of a 4-bit period counter. A new
// ratio requested while running is parked in a pending register and only
// takes effect on the last cycle of the current period. This means no
// truncated or stretched pulse ever appears on clk_out.
//
// Configuration macro: CLK_DIV_ODD_EN
//   defined   -> odd ratios 3..15 are accepted. The high phase is
//                ceil(N/2) cycles and the low phase is floor(N/2) cycles.
//   undefined -> only even ratios 2..14 are accepted. Odd requests are
//                treated as illegal. DEFAULT_DIV must then be even.
//
// Illegal requests still complete the handshake. They are discarded, and err
// pulses for one cycle after the transfer.
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned DEFAULT_DIV = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       req_valid,
    input  logic [3:0] req_div,
    output logic       req_ready,
    output logic       clk_out,
    output logic       tick,
    output logic [3:0] cur_div,
    output logic       err
);

    localparam logic [3:0] DEF_DIV = 4'(DEFAULT_DIV);

    // IDLE: stopped, with clk_out low.
    // RUN:  dividing, with no pending change.
    // PEND: dividing, with a new ratio waiting for the wrap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cur_div_q, cur_div_d;
    logic [3:0] pend_q, pend_d;
    logic       clk_out_q, clk_out_d;
    logic       err_q, err_d;

    logic       running;
    logic       wrap;
    logic [4:0] half;
    logic       high_phase;
    logic [3:0] cnt_next;
    logic       ready_int;
    logic       accept;
    logic       req_legal;
    logic       take_new;

    // Decode the period position and qualify the incoming request.
    always_comb begin
        running    = (state_q != ST_IDLE);
        wrap       = running && (cnt_q == (cur_div_q - 4'd1));
        // The high phase is ceil(N/2). It is computed in 5 bits so that
        // N=15 does not overflow.
        half       = ({1'b0, cur_div_q} + 5'd1) >> 1;
        high_phase = ({1'b0, cnt_q} < half);
        cnt_next   = wrap ? 4'd0 : (cnt_q + 4'd1);
        ready_int  = (state_q != ST_PEND);
        accept     = req_valid && ready_int;
`ifdef CLK_DIV_ODD_EN
        req_legal  = (req_div >= 4'd2);
`else
        req_legal  = (req_div >= 4'd2) && !req_div[0];
`endif
        take_new   = accept && req_legal;
    end

    // Compute the next state, the counter, the ratio registers and the
    // registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        clk_out_d = 1'b0;
        // An illegal request is consumed like a legal one. The only trace it
        // leaves is this pulse.
        err_d     = accept && !req_legal;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = 4'd0;
                clk_out_d = 1'b0;
                // While stopped, there is no period to protect, so the new
                // ratio is applied at once.
                if (take_new) begin
                    cur_div_d = req_div;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                clk_out_d = high_phase;
                cnt_d     = cnt_next;
                if (wrap && !en) begin
                    // The stop takes effect at the wrap. A request that lands
                    // on this same edge has no later wrap to wait for, so it
                    // is applied directly, just as it would be in IDLE.
                    state_d = ST_IDLE;
                    if (take_new) begin
                        cur_div_d = req_div;
                    end
                end else if (take_new) begin
                    // A request that arrives on a wrap cycle also parks here.
                    // It is applied at the following wrap.
                    pend_d  = req_div;
                    state_d = ST_PEND;
                end
            end

            ST_PEND: begin
                clk_out_d = high_phase;
                cnt_d     = cnt_next;
                if (wrap) begin
                    // The current period ends here. The next period starts at
                    // cnt=0 with the new ratio, so clk_out stays low through
                    // this boundary and rises one cycle later.
                    cur_div_d = pend_q;
                    pend_d    = 4'd0;
                    state_d   = en ? ST_RUN : ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 4'd0;
                pend_d    = 4'd0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    // Hold all state registers. Reset is asynchronous and returns the block
    // to the stopped, default-ratio condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            cur_div_q <= DEF_DIV;
            pend_q    <= 4'd0;
            clk_out_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            err_q     <= err_d;
        end
    end

    // Drive the outputs. tick and req_ready decode registered state only, so
    // reset forces them to their idle values immediately.
    always_comb begin
        clk_out   = clk_out_q;
        tick      = wrap;
        req_ready = ready_int;
        cur_div   = cur_div_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// A cycle-level reference model predicts clk_out, tick, req_ready, err and
// cur_div for every cycle. The expected values are pushed into a scoreboard
// queue when the inputs are driven, then popped and compared on the following
// falling edge. Directed scenarios add window checks: the number of high
// cycles and ticks in a fixed span, and the ratio in effect.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    logic       clk;
    logic       reset;
    logic       en;
    logic       req_valid;
    logic [3:0] req_div;
    logic       req_ready;
    logic       clk_out;
    logic       tick;
    logic [3:0] cur_div;
    logic       err;

`ifdef CLK_DIV_ODD_EN
    localparam bit ODD_OK = 1'b1;
`else
    localparam bit ODD_OK = 1'b0;
`endif

    clk_div_ctrl #(.DEFAULT_DIV(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int clk_o;
        int tick_o;
        int ready_o;
        int err_o;
        int div_o;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state. It tracks the position in the period and the
    // ratio in effect.
    int m_st;    // 0 stopped, 1 running, 2 running with a change parked
    int m_cnt;
    int m_div;
    int m_pend;
    int m_clk;
    int m_err;

    // Window accumulators. They are updated on every scoreboard sample.
    int hi_cnt;
    int tk_cnt;
    int er_cnt;

    task automatic chk(input string tag, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_cnt  = 0;
        m_div  = 6;
        m_pend = 0;
        m_clk  = 0;
        m_err  = 0;
    endtask

    // Advance the model by one rising edge, given the inputs sampled there.
    task automatic model_step(input bit e, input bit v, input int d);
        bit legal, acc, at_end;
        int n_st, n_cnt, n_div, n_pend, n_clk;
        legal  = (d >= 2) && (ODD_OK || (d % 2 == 0));
        acc    = v && (m_st != 2);
        at_end = (m_st != 0) && (m_cnt == m_div - 1);
        n_st = m_st; n_div = m_div; n_pend = m_pend;
        if (m_st == 0) begin
            n_cnt = 0;
            n_clk = 0;
            if (acc && legal) n_div = d;
            if (e) n_st = 1;
        end else begin
            // The high phase covers the first ceil(N/2) counts of a period.
            n_clk = (m_cnt * 2 < m_div) ? 1 : 0;
            n_cnt = at_end ? 0 : m_cnt + 1;
            if (m_st == 1) begin
                if (at_end && !e) begin
                    n_st = 0;
                    if (acc && legal) n_div = d;
                end else if (acc && legal) begin
                    n_pend = d;
                    n_st   = 2;
                end
            end else if (at_end) begin
                n_div  = m_pend;
                n_pend = 0;
                n_st   = e ? 1 : 0;
            end
        end
        m_err = (acc && !legal) ? 1 : 0;
        m_st = n_st; m_cnt = n_cnt; m_div = n_div; m_pend = n_pend; m_clk = n_clk;
    endtask

    task automatic push_exp();
        exp_t x;
        x.clk_o   = m_clk;
        x.tick_o  = ((m_st != 0) && (m_cnt == m_div - 1)) ? 1 : 0;
        x.ready_o = (m_st != 2) ? 1 : 0;
        x.err_o   = m_err;
        x.div_o   = m_div;
        exp_q.push_back(x);
    endtask

    task automatic compare_out();
        exp_t x;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            x = exp_q.pop_front();
            chk("clk_out",   int'(clk_out),   x.clk_o);
            chk("tick",      int'(tick),      x.tick_o);
            chk("req_ready", int'(req_ready), x.ready_o);
            chk("err",       int'(err),       x.err_o);
            chk("cur_div",   int'(cur_div),   x.div_o);
        end
        hi_cnt += int'(clk_out);
        tk_cnt += int'(tick);
        er_cnt += int'(err);
    endtask

    // Run one clock cycle: check the present outputs, then drive the inputs
    // for the next rising edge and queue what that edge should produce.
    task automatic cycle(input bit e, input bit v, input int d);
        @(negedge clk);
        compare_out();
        reset     = 1'b1;
        en        = e;
        req_valid = v;
        req_div   = 4'(d);
        model_step(e, v, d);
        push_exp();
    endtask

    task automatic clear_win();
        hi_cnt = 0;
        tk_cnt = 0;
        er_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_out();
        reset     = 1'b0;
        en        = 1'b0;
        req_valid = 1'b0;
        model_reset();
        push_exp();
        #1;
        chk("rst_clk_out", int'(clk_out),   0);
        chk("rst_tick",    int'(tick),      0);
        chk("rst_ready",   int'(req_ready), 1);
        chk("rst_err",     int'(err),       0);
        chk("rst_div",     int'(cur_div),   6);
        @(negedge clk);
        compare_out();
        push_exp();
    endtask

    initial begin
        int lim;
        reset     = 1'b1;
        en        = 1'b0;
        req_valid = 1'b0;
        req_div   = 4'd0;
        clear_win();
        #2;
        reset = 1'b0;
        model_reset();
        push_exp();
        #1;
        chk("por_clk_out", int'(clk_out),   0);
        chk("por_ready",   int'(req_ready), 1);
        chk("por_div",     int'(cur_div),   6);

        // Free-running at the default ratio: 3 high, 3 low, a tick every 6th cycle.
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);
        clear_win();
        for (int i = 0; i < 12; i++) cycle(1, 0, 0);
        chk("def_high", hi_cnt, 6);
        chk("def_tick", tk_cnt, 2);
        chk("def_div",  int'(cur_div), 6);

        // Change to 4 in mid-period. The old ratio holds until the wrap.
        lim = 0;
        while (!(m_st == 1 && m_cnt == 2) && lim < 40) begin cycle(1, 0, 0); lim++; end
        chk("wait_cnt2", (lim < 40) ? 1 : 0, 1);
        cycle(1, 1, 4);
        @(posedge clk); #1;
        chk("chg_ready", int'(req_ready), 0);
        chk("chg_div",   int'(cur_div),   6);
        lim = 0;
        while (m_div != 4 && lim < 40) begin cycle(1, 0, 0); lim++; end
        chk("wait_div4", (lim < 40) ? 1 : 0, 1);
        clear_win();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        chk("div4_high", hi_cnt, 4);
        chk("div4_tick", tk_cnt, 2);

        // Illegal ratios 1 and 0: each is consumed with one err pulse, and
        // the ratio is left unchanged.
        clear_win();
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        chk("ill_err", er_cnt, 2);
        chk("ill_div", int'(cur_div), 4);

        // Odd ratio 5. It is legal only when odd ratios are enabled.
        clear_win();
        cycle(1, 1, 5);
        for (int i = 0; i < 14; i++) cycle(1, 0, 0);
        clear_win();
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        if (ODD_OK) begin
            chk("odd_div",  int'(cur_div), 5);
            chk("odd_high", hi_cnt, 6);
        end else begin
            chk("odd_div",  int'(cur_div), 4);
            chk("odd_high", hi_cnt, 5);
        end

        // Return to 6. Park 8, then drop en at cnt=1 and let the period finish.
        cycle(1, 1, 6);
        lim = 0;
        while (!(m_st == 1 && m_div == 6 && m_cnt == 0) && lim < 40) begin cycle(1, 0, 0); lim++; end
        chk("wait_div6", (lim < 40) ? 1 : 0, 1);
        cycle(1, 1, 8);
        cycle(0, 0, 0);
        lim = 0;
        while (m_st != 0 && lim < 20) begin cycle(0, 0, 0); lim++; end
        chk("wait_idle", (lim < 20) ? 1 : 0, 1);
        cycle(0, 0, 0);
        chk("stop_div", int'(cur_div), 8);
        chk("stop_clk", int'(clk_out), 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        clear_win();
        for (int i = 0; i < 16; i++) cycle(1, 0, 0);
        chk("div8_high", hi_cnt, 8);
        chk("div8_tick", tk_cnt, 2);

        // Reset in PEND at cnt=3 while running at 6. The parked ratio is lost.
        cycle(1, 1, 6);
        lim = 0;
        while (!(m_st == 1 && m_div == 6 && m_cnt == 0) && lim < 40) begin cycle(1, 0, 0); lim++; end
        chk("wait_div6b", (lim < 40) ? 1 : 0, 1);
        cycle(1, 1, 4);
        lim = 0;
        while (!(m_st == 2 && m_cnt == 3) && lim < 40) begin cycle(1, 0, 0); lim++; end
        chk("wait_pend3", (lim < 40) ? 1 : 0, 1);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        clear_win();
        for (int i = 0; i < 12; i++) cycle(1, 0, 0);
        chk("post_rst_high", hi_cnt, 6);
        chk("post_rst_div",  int'(cur_div), 6);

        // Random traffic of enables and requests, checked cycle by cycle by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 15)));
        end
        @(negedge clk);
        compare_out();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
